// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by instruction fetch and load/store
//
// Purpose:
//   Arbitrates between the IFU (read-only) and the LSU for one memory port.
//   LSU has fixed priority. One request is latched and held stable on the
//   memory port until mem_ready, then the winner gets a one-cycle response.
//   FSM: IDLE -> ISSUE -> RESP -> IDLE; at most one access outstanding.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an ISSUE that waits
//   TIMEOUT_CYCLES cycles without mem_ready (returns 32'hDEAD_BEEF, sets err).
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   ifu_req_valid/addr/ready       fetch request handshake
//   ifu_rsp_valid/data             fetch response pulse and held data
//   lsu_req_valid/wen/addr/wdata/wmask/ready   load/store request handshake
//   lsu_rsp_valid/data             load/store response pulse and held data (0 for stores)
//   mem_valid/wen/addr/wdata/wmask memory request, held until mem_ready
//   mem_ready, mem_rdata           memory completion and read data
//   busy                           FSM not in IDLE
//   err                            sticky timeout flag
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_req_ready,
  output logic                    ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rsp_data,
  input  logic                    lsu_req_valid,
  input  logic                    lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_req_ready,
  output logic                    lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rsp_data,
  output logic                    mem_valid,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    err
);

  localparam int MASK_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_lsu_q;
  logic                    wen_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [MASK_W-1:0]       wmask_q;
  logic [DATA_WIDTH-1:0]   ifu_data_q;
  logic [DATA_WIDTH-1:0]   lsu_data_q;

  logic accept_lsu;
  logic accept_ifu;
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    accept_lsu    = 1'b0;
    accept_ifu    = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    mem_valid     = 1'b0;
    mem_wen       = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // Ready only to the winner, and never while reset is asserted so that
        // all outputs read 0 during reset.
        accept_lsu    = rst && lsu_req_valid;
        accept_ifu    = rst && ifu_req_valid && !lsu_req_valid;
        lsu_req_ready = accept_lsu;
        ifu_req_ready = accept_ifu;
        if (accept_lsu || accept_ifu) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        mem_wen   = wen_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
        if (mem_ready || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ifu_rsp_valid = !owner_lsu_q;
        lsu_rsp_valid = owner_lsu_q;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched request and response data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_lsu_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_data_q  <= '0;
      lsu_data_q  <= '0;
    end else if (accept_lsu) begin
      owner_lsu_q <= 1'b1;
      wen_q       <= lsu_req_wen;
      addr_q      <= lsu_req_addr;
      // Loads present zero write data and mask on the memory port.
      wdata_q     <= lsu_req_wen ? lsu_req_wdata : '0;
      wmask_q     <= lsu_req_wen ? lsu_req_wmask : '0;
    end else if (accept_ifu) begin
      owner_lsu_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= ifu_req_addr;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else if (state_q == S_ISSUE && mem_ready) begin
      if (owner_lsu_q) begin
        lsu_data_q <= wen_q ? '0 : mem_rdata;
      end else begin
        ifu_data_q <= mem_rdata;
      end
    end else if (timeout_hit) begin
      if (owner_lsu_q) begin
        lsu_data_q <= DATA_WIDTH'(32'hDEAD_BEEF);
      end else begin
        ifu_data_q <= DATA_WIDTH'(32'hDEAD_BEEF);
      end
    end
  end

  assign ifu_rsp_data = ifu_data_q;
  assign lsu_rsp_data = lsu_data_q;

  // ---------------------------------------------------------------------------
  // Optional ISSUE timeout
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Counter holds the number of ISSUE cycles already spent without mem_ready;
  // the cycle that would bring it to TIMEOUT_CYCLES aborts. mem_ready wins.
  assign timeout_hit = (state_q == S_ISSUE) && !mem_ready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept_lsu || accept_ifu) begin
        cnt_q <= '0;
      end else if (state_q == S_ISSUE && !mem_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  // TIMEOUT_CYCLES has no effect in this build.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h5A5A_5A5A;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected responses, in order.
  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      check("single_rsp", 32'(ifu_rsp_valid & lsu_rsp_valid), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: ifu=%0b lsu=%0b with empty scoreboard", ifu_rsp_valid, lsu_rsp_valid);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", 32'(lsu_rsp_valid), 32'(e.lsu));
        check("rsp_data", e.lsu ? lsu_rsp_data : ifu_rsp_data, e.data);
      end
    end
  end

  // Memory model: checks the held request each ISSUE cycle, answers after mem_delay cycles.
  int          mem_delay    = 0;
  logic [31:0] mem_rdata_val = 32'h0;
  int          wait_cnt     = 0;
  int          issue_cycles = 0;
  logic [31:0] exp_addr  = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  logic        exp_wen   = 1'b0;
  logic [3:0]  exp_wmask = 4'h0;

  always @(negedge clk) begin
    if (mem_valid) begin
      check("mem_addr", mem_addr, exp_addr);
      check("mem_wen", 32'(mem_wen), 32'(exp_wen));
      check("mem_wdata", mem_wdata, exp_wdata);
      check("mem_wmask", 32'(mem_wmask), 32'(exp_wmask));
      mem_ready = (wait_cnt >= mem_delay);
      mem_rdata = mem_ready ? mem_rdata_val : 32'h5A5A_5A5A;
      wait_cnt++;
      issue_cycles = wait_cnt;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      wait_cnt  = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic set_mem(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [31:0] rd, input int dly);
    exp_addr      = a;
    exp_wen       = w;
    exp_wdata     = w ? wd : 32'h0;
    exp_wmask     = w ? wm : 4'h0;
    mem_rdata_val = rd;
    mem_delay     = dly;
  endtask

  task automatic lsu_op(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [31:0] rd, input int dly,
                        input logic [31:0] exp_data);
    set_mem(a, w, wd, wm, rd, dly);
    exp_q.push_back('{1'b1, exp_data});
    lsu_req_valid = 1'b1;
    lsu_req_wen   = w;
    lsu_req_addr  = a;
    lsu_req_wdata = wd;
    lsu_req_wmask = wm;
    #1;
    check("lsu_ready", 32'(lsu_req_ready), 32'd1);
    @(negedge clk);
    // Scramble inputs after accept: the port must keep the latched values.
    lsu_req_valid = 1'b0;
    lsu_req_addr  = 32'hFFFF_FFFF;
    lsu_req_wdata = 32'h0;
    lsu_req_wmask = 4'h0;
    wait_idle();
  endtask

  task automatic ifu_op(input logic [31:0] a, input logic [31:0] rd, input int dly);
    set_mem(a, 1'b0, 32'h0, 4'h0, rd, dly);
    exp_q.push_back('{1'b0, rd});
    ifu_req_valid = 1'b1;
    ifu_req_addr  = a;
    #1;
    check("ifu_ready", 32'(ifu_req_ready), 32'd1);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    ifu_req_addr  = 32'hFFFF_FFFF;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int prev_cyc;
    int n;

    rst           = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 32'h8000_1000;
    lsu_req_wdata = 32'h0;
    lsu_req_wmask = 4'h0;

    // Reset state, with requests pending that must not be granted.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
    check("rst_ifu_data", ifu_rsp_data, 32'd0);
    check("rst_lsu_data", lsu_rsp_data, 32'd0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);

    // 1. IFU alone, accept->rsp = 2 cycles.
    set_mem(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 0);
    exp_q.push_back('{1'b0, 32'h0010_0073});
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    check("t1_ifu_ready", 32'(ifu_req_ready), 32'd1);
    check("t1_lsu_ready", 32'(lsu_req_ready), 32'd0);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    check("t1_mem_valid", 32'(mem_valid), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_in_issue", 32'(ifu_req_ready), 32'd0);
    @(negedge clk);
    check("t1_rsp_at_2", 32'(ifu_rsp_valid), 32'd1);
    @(negedge clk);
    check("t1_rsp_one_pulse", 32'(ifu_rsp_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_data_held", ifu_rsp_data, 32'h0010_0073);

    // 2. Both valid: LSU wins, IFU granted at next IDLE.
    set_mem(32'h8000_1000, 1'b0, 32'h0, 4'h0, 32'h1111_2222, 0);
    exp_q.push_back('{1'b1, 32'h1111_2222});
    exp_q.push_back('{1'b0, 32'h2222_3333});
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 32'h8000_1000;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0004;
    #1;
    check("t2_lsu_ready", 32'(lsu_req_ready), 32'd1);
    check("t2_ifu_ready", 32'(ifu_req_ready), 32'd0);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    n = 0;
    while (!ifu_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_ifu_grant", 32'(ifu_req_ready), 32'd1);
    check("t2_ifu_grant_delay", 32'(n), 32'd2);
    set_mem(32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h2222_3333, 0);
    @(negedge clk);
    ifu_req_valid = 1'b0;
    wait_idle();

    // 3. sh with 5 wait cycles: port stable 6 ISSUE cycles, store returns 0.
    lsu_op(1'b1, 32'h8000_2002, 32'h1234_ABCD, 4'b0011, 32'hFFFF_FFFF, 5, 32'h0);
    check("t3_issue_cycles", 32'(issue_cycles), 32'd6);
    check("t3_lsu_data_store", lsu_rsp_data, 32'h0);

    // 4. Reset during ISSUE abandons the access.
    set_mem(32'h8000_3000, 1'b0, 32'h0, 4'h0, 32'hCAFE_0000, 1000);
    lsu_req_valid = 1'b1;
    lsu_req_wen   = 1'b0;
    lsu_req_addr  = 32'h8000_3000;
    #1;
    check("t4_lsu_ready", 32'(lsu_req_ready), 32'd1);
    @(negedge clk);
    lsu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t4_mem_valid", 32'(mem_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_rsp", 32'(lsu_rsp_valid | ifu_rsp_valid), 32'd0);
    check("t4_ifu_data_cleared", ifu_rsp_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t4_still_no_rsp", 32'(lsu_rsp_valid | ifu_rsp_valid), 32'd0);
    ifu_op(32'h8000_0008, 32'h0000_0013, 1);

    // 5. Back-to-back LSU loads, immediate mem_ready: accepts 3 cycles apart.
    b2b_addr[0] = 32'h8000_4000; b2b_data[0] = 32'hAAAA_0001;
    b2b_addr[1] = 32'h8000_4005; b2b_data[1] = 32'hAAAA_0002;
    b2b_addr[2] = 32'h8000_4008; b2b_data[2] = 32'hAAAA_0003;
    prev_cyc = 0;
    lsu_req_wen   = 1'b0;
    lsu_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lsu_req_addr = b2b_addr[i];
      #1;
      n = 0;
      while (!lsu_req_ready && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("t5_ready", 32'(lsu_req_ready), 32'd1);
      set_mem(b2b_addr[i], 1'b0, 32'h0, 4'h0, b2b_data[i], 0);
      exp_q.push_back('{1'b1, b2b_data[i]});
      if (i > 0) check("t5_spacing", 32'(cyc - prev_cyc), 32'd3);
      prev_cyc = cyc;
      @(negedge clk);
    end
    lsu_req_valid = 1'b0;
    wait_idle();
    check("t5_last_data", lsu_rsp_data, 32'hAAAA_0003);

`ifdef MEM_ARB_TIMEOUT_EN
    // 6. Timeout after 4 ISSUE cycles.
    lsu_op(1'b0, 32'h8000_5000, 32'h0, 4'h0, 32'h0, 100000, 32'hDEAD_BEEF);
    check("t6_issue_cycles", 32'(issue_cycles), 32'd4);
    check("t6_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", 32'(err), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t6_err_cleared", 32'(err), 32'd0);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
